alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-driven controller for the 16-bit register-file/ALU datapath. It accepts one micro-command: ALU op, source registers or immediate, destination register, and repeat count. It then sequences the datapath control lines (alu_op, muxes, regs_en, imm) through execute/write-back cycles, repeating up to N times. Iteration stops early on selected ALU flags. It sits between the top-level program FSM and the datapath, replacing hard-coded per-program FSMs.

Parameters:
NREGS, 16, number of registers; width of regs_en.
OPW, 8, ALU opcode width.
CNTW, 8, repeat-count width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command (IDLE only).
cmd_op  in  OPW  ALU opcode driven onto alu_op.
cmd_ra  in  4  A-mux register select.
cmd_rb  in  4  B-mux register select.
cmd_rd  in  4  destination register.
cmd_use_imm  in  1  1 = B operand is cmd_imm.
cmd_imm  in  16  immediate value.
cmd_count  in  CNTW  repeat count; 0 is treated as 1.
cmd_stop_mask  in  5  early-stop flag mask.
flag_in  in  5  ALU flag outputs (combinational from the datapath).
alu_op  out  OPW  ALU opcode.
muxes  out  8  {A select[7:4], B select[3:0]}.
imm_sel  out  1  B mux takes imm.
imm  out  16  immediate to datapath.
regs_en  out  NREGS  one-hot register write enable.
flags  out  5  flags latched at last write.
iter_done  out  CNTW  completed write-backs of current/last command.
busy  out  1  command in progress.
done  out  1  one-cycle pulse at completion.
stopped  out  1  last command ended by stop mask (held until next accept).

Behaviour:
- All outputs are registered. Reset (reset=0) is asynchronous and forces:
  - state IDLE; cmd_ready=1 after reset deasserts.
  - alu_op=0, muxes=0, imm_sel=0, imm=0, regs_en=0.
  - flags=0, iter_done=0, busy=0, done=0, stopped=0.
- States: IDLE, EXEC, WRITE, DONE.
- IDLE:
  - cmd_ready=1. A handshake (cmd_valid & cmd_ready at a rising edge) latches all cmd_* fields.
  - remaining = (cmd_count==0) ? 1 : cmd_count.
  - Clears iter_done and stopped; sets busy=1; goes to EXEC.
- EXEC (1 cycle):
  - alu_op=op; muxes={ra,rb}; imm_sel=use_imm; imm=imm.
  - regs_en=0; cmd_ready=0.
- WRITE (1 cycle):
  - Operand/op outputs are held; regs_en = 1<<rd.
  - At the end of the cycle: flags<=flag_in; iter_done+1; remaining-1.
  - stop = |(flag_in & stop_mask).
  - If stop, or remaining was 1: go to DONE, with stopped<=stop only when remaining>1.
  - Otherwise go back to EXEC.
- DONE (1 cycle):
  - done=1, busy=0, regs_en=0; control outputs hold their last values.
  - Goes to IDLE; cmd_ready=1 from the next cycle.
- Latency: accept edge at cycle 0 gives EXEC at 1, WRITE at 2, ..., WRITE at 2N, done high during cycle 2N+1. N=1 gives done in cycle 3.
- cmd_valid while busy is ignored; the command is neither latched nor dropped silently (cmd_ready=0, so the requester holds it).
- iter_done saturates at 2^CNTW-1. It cannot overflow, since remaining is at most 2^CNTW-1.
- Stop on the final iteration: stopped stays 0 (normal completion takes precedence).
- A stop-mask hit during EXEC is ignored; flags are evaluated only during WRITE.
- Reset mid-command: the command is aborted immediately; regs_en drops asynchronously; no done pulse.
- regs_en is never multi-hot and is nonzero only in WRITE.

Test Plan:
- Reset: hold reset=0 2 cycles with random inputs -> all outputs 0; after release cmd_ready=1.
- Single op: op=ADD, ra=1, rb=2, rd=5, count=1 -> EXEC in cycle 1 with muxes=8'h12. WRITE in cycle 2 with regs_en=16'h0020. done pulse in cycle 3; iter_done=1; stopped=0.
- Count 0 and immediate: count=0, use_imm=1, imm=16'h0007, rd=3 -> exactly one write (regs_en=16'h0008), imm_sel=1, done in cycle 3.
- Repeat: count=4, rd=1, stop_mask=0 -> four WRITE cycles (2,4,6,8) each with regs_en=16'h0002; done in cycle 9; iter_done=4.
- Early stop: count=5, stop_mask=5'b00001, flag_in[0]=1 during the 2nd WRITE -> done in cycle 5; iter_done=2; stopped=1; flags latched =flag_in. Repeat with flag hit on the 5th WRITE -> stopped=0.
- Busy/abort: second cmd_valid during busy -> not accepted; it is accepted in the cycle after done. Separately, reset=0 in the middle of WRITE -> regs_en=0 immediately, no done pulse, IDLE after release.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: runs one ALU micro-command through repeated execute/write-back cycles with flag-based early stop
module alu_cmd_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [3:0]       cmd_ra,
  input  logic [3:0]       cmd_rb,
  input  logic [3:0]       cmd_rd,
  input  logic             cmd_use_imm,
  input  logic [15:0]      cmd_imm,
  input  logic [CNTW-1:0]  cmd_count,
  input  logic [4:0]       cmd_stop_mask,
  input  logic [4:0]       flag_in,
  output logic [OPW-1:0]   alu_op,
  output logic [7:0]       muxes,
  output logic             imm_sel,
  output logic [15:0]      imm,
  output logic [NREGS-1:0] regs_en,
  output logic [4:0]       flags,
  output logic [CNTW-1:0]  iter_done,
  output logic             busy,
  output logic             done,
  output logic             stopped
);
  typedef enum logic [1:0] {IDLE, EXEC, WRITE, DONE} state_t;
  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [7:0]       muxes_q, muxes_d;
  logic             imm_sel_q, imm_sel_d;
  logic [15:0]      imm_q, imm_d;
  logic [NREGS-1:0] regs_en_q, regs_en_d;
  logic [4:0]       flags_q, flags_d;
  logic [CNTW-1:0]  iter_done_q, iter_done_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stopped_q, stopped_d;
  logic [3:0]       rd_q, rd_d;
  logic [4:0]       mask_q, mask_d;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic             stop, last;
  assign stop = |(flag_in & mask_q);
  assign last = rem_q == CNTW'(1);
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    alu_op_d    = alu_op_q;
    muxes_d     = muxes_q;
    imm_sel_d   = imm_sel_q;
    imm_d       = imm_q;
    regs_en_d   = '0;
    flags_d     = flags_q;
    iter_done_d = iter_done_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stopped_d   = stopped_q;
    rd_d        = rd_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = EXEC;
          cmd_ready_d = 1'b0;
          alu_op_d    = cmd_op;
          muxes_d     = {cmd_ra, cmd_rb};
          imm_sel_d   = cmd_use_imm;
          imm_d       = cmd_imm;
          rd_d        = cmd_rd;
          mask_d      = cmd_stop_mask;
          rem_d       = (cmd_count == '0) ? CNTW'(1) : cmd_count;
          iter_done_d = '0;
          stopped_d   = 1'b0;
          busy_d      = 1'b1;
        end
      end
      EXEC: begin
        state_d   = WRITE;
        regs_en_d = NREGS'(1) << rd_q;
      end
      WRITE: begin
        flags_d     = flag_in;
        iter_done_d = &iter_done_q ? iter_done_q : iter_done_q + CNTW'(1);
        rem_d       = rem_q - CNTW'(1);
        state_d     = (stop || last) ? DONE : EXEC;
        // a hit on the final write counts as normal completion
        stopped_d   = stop && !last;
        done_d      = stop || last;
        busy_d      = !(stop || last);
      end
      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      alu_op_q    <= '0;
      muxes_q     <= '0;
      imm_sel_q   <= 1'b0;
      imm_q       <= '0;
      regs_en_q   <= '0;
      flags_q     <= '0;
      iter_done_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stopped_q   <= 1'b0;
      rd_q        <= '0;
      mask_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      alu_op_q    <= alu_op_d;
      muxes_q     <= muxes_d;
      imm_sel_q   <= imm_sel_d;
      imm_q       <= imm_d;
      regs_en_q   <= regs_en_d;
      flags_q     <= flags_d;
      iter_done_q <= iter_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stopped_q   <= stopped_d;
      rd_q        <= rd_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign alu_op    = alu_op_q;
  assign muxes     = muxes_q;
  assign imm_sel   = imm_sel_q;
  assign imm       = imm_q;
  assign regs_en   = regs_en_q;
  assign flags     = flags_q;
  assign iter_done = iter_done_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stopped   = stopped_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_op = '0, cmd_count = '0;
  logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
  logic        cmd_use_imm = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic [4:0]  cmd_stop_mask = '0, flag_in = '0;
  logic [7:0]  alu_op, muxes, iter_done;
  logic        imm_sel, busy, done, stopped;
  logic [15:0] imm, regs_en;
  logic [4:0]  flags;
  int n_chk = 0, n_fail = 0;
  typedef struct {int done_cyc; logic [7:0] iters; logic stopped; logic [4:0] flags;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_count(cmd_count),
    .cmd_stop_mask(cmd_stop_mask), .flag_in(flag_in), .alu_op(alu_op),
    .muxes(muxes), .imm_sel(imm_sel), .imm(imm), .regs_en(regs_en),
    .flags(flags), .iter_done(iter_done), .busy(busy), .done(done), .stopped(stopped)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic scramble();
    cmd_op = 8'($urandom); cmd_ra = 4'($urandom); cmd_rb = 4'($urandom); cmd_rd = 4'($urandom);
    cmd_use_imm = 1'($urandom); cmd_imm = 16'($urandom); cmd_count = 8'($urandom);
    cmd_stop_mask = 5'($urandom);
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input logic ui, input logic [15:0] im,
                         input logic [7:0] cnt, input logic [4:0] mask, input int hit,
                         input logic [4:0] hf, input logic garbage);
    int n, it, t;
    exp_t e, g;
    n = (cnt == 0) ? 1 : int'(cnt);
    it = (hit != 0 && hit <= n && (hf & mask) != 0) ? hit : n;
    e.iters = 8'(it);
    e.stopped = it < n;
    e.flags = (it == hit) ? hf : 5'b0;
    e.done_cyc = 2 * it + 1;
    sb.push_back(e);
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    chk("ready_wait", 32'(t < 20), 1);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_use_imm = ui; cmd_imm = im;
    cmd_count = cnt; cmd_stop_mask = mask; cmd_valid = 1'b1; flag_in = '0;
    @(posedge clk); #1;
    cmd_valid = garbage;
    scramble();
    for (int k = 1; k <= e.done_cyc; k++) begin
      @(negedge clk);
      if (k == e.done_cyc) begin
        g = sb.pop_front();
        chk("done", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("iter_done", 32'(iter_done), 32'(g.iters));
        chk("stopped", 32'(stopped), 32'(g.stopped));
        chk("flags", 32'(flags), 32'(g.flags));
        chk("regs_en_done", 32'(regs_en), 0);
        cmd_valid = 1'b0;
        flag_in = '0;
      end else begin
        chk("done_low", 32'(done), 0);
        chk("busy", 32'(busy), 1);
        chk("cmd_ready_busy", 32'(cmd_ready), 0);
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("muxes", 32'(muxes), 32'({ra, rb}));
        chk("imm_sel", 32'(imm_sel), 32'(ui));
        chk("imm", 32'(imm), 32'(im));
        chk("regs_en", 32'(regs_en), (k % 2 == 0) ? 32'(16'(1) << rd) : 32'(0));
        flag_in = (k % 2 == 1) ? 5'h1f : ((k / 2 == hit) ? hf : 5'h00);
      end
    end
    @(negedge clk);
    chk("ready_after", 32'(cmd_ready), 1);
    chk("done_pulse", 32'(done), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    scramble();
    cmd_valid = 1'b1;
    flag_in = 5'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_muxes", 32'(muxes), 0);
    chk("rst_imm_sel", 32'(imm_sel), 0);
    chk("rst_imm", 32'(imm), 0);
    chk("rst_regs_en", 32'(regs_en), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_iter_done", 32'(iter_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stopped", 32'(stopped), 0);
    cmd_valid = 1'b0;
    flag_in = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    run_cmd(8'h01, 4'd1, 4'd2, 4'd5, 1'b0, 16'h0000, 8'd1, 5'b00000, 0, 5'h00, 1'b0);
    run_cmd(8'h02, 4'd4, 4'd0, 4'd3, 1'b1, 16'h0007, 8'd0, 5'b00000, 0, 5'h00, 1'b0);
    run_cmd(8'h03, 4'd6, 4'd9, 4'd1, 1'b0, 16'h1234, 8'd4, 5'b00000, 2, 5'h1f, 1'b0);
    run_cmd(8'h04, 4'd2, 4'd3, 4'd9, 1'b0, 16'hbeef, 8'd5, 5'b00001, 2, 5'b00001, 1'b0);
    run_cmd(8'h05, 4'd7, 4'd8, 4'd15, 1'b1, 16'h00ff, 8'd5, 5'b00001, 5, 5'b10001, 1'b0);
    run_cmd(8'h06, 4'd3, 4'd4, 4'd0, 1'b0, 16'h0000, 8'd2, 5'b00000, 0, 5'h00, 1'b1);
    run_cmd(8'h07, 4'd5, 4'd5, 4'd12, 1'b1, 16'h8001, 8'd1, 5'b00010, 1, 5'b00010, 1'b0);
    run_cmd(8'h08, 4'd9, 4'd1, 4'd2, 1'b0, 16'h0000, 8'd255, 5'b00000, 0, 5'h00, 1'b0);
    cmd_op = 8'h09; cmd_ra = 4'd1; cmd_rb = 4'd1; cmd_rd = 4'd7; cmd_use_imm = 1'b0;
    cmd_imm = '0; cmd_count = 8'd3; cmd_stop_mask = '0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_write", 32'(regs_en), 32'h0080);
    #2 reset = 1'b0;
    #1;
    chk("abort_regs_en", 32'(regs_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_done_after", 32'(done), 0);
    chk("abort_busy_after", 32'(busy), 0);
    run_cmd(8'h0a, 4'd8, 4'd7, 4'd4, 1'b0, 16'h0000, 8'd2, 5'b00000, 0, 5'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
